// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage sitting directly downstream of the program counter. It takes the
// current PC and issues in-order word reads to instruction memory. Each returned
// word is paired with the PC it was fetched from and buffered in a small FIFO.
// Decode takes entries from that FIFO over a valid/ready handshake.
//
// A single credit pool of DEPTH slots covers both the reads in flight and the
// entries already buffered. Because of this, a response always has a FIFO slot
// to land in, and imem never needs to be stalled.
//
// When the PC is redirected:
//   - the FIFO is cleared;
//   - the reads still in flight are counted off;
//   - their responses are dropped when they arrive.
//
// A misaligned PC is never sent to memory. Once the pipe is empty, the stage
// emits one fault entry carrying a NOP, then parks until the next redirect.
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   pc           in  32  current PC from program_counter
//   branch_en    in   1  redirect; program_counter loads its target this edge
//   pc_advance   out  1  PC consumed this cycle; program_counter increments
//   imem_req     out  1  read request
//   imem_addr    out 32  read address (= pc)
//   imem_gnt     in   1  request accepted this cycle
//   imem_rvalid  in   1  read data valid (in order, >=1 cycle after grant)
//   imem_rdata   in  32  read data
//   if_valid     out  1  FIFO head valid toward decode
//   if_ready     in   1  decode accepts the head
//   if_instr     out 32  head instruction word
//   if_pc        out 32  head PC
//   if_fault     out  1  head is a misaligned-fetch fault entry
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        branch_en,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0]    ST_FETCH = 1'b0;
    localparam logic [0:0]    ST_FAULT = 1'b1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

    // Circular pointer increment.
    // The wrap is explicit so that DEPTH does not have to be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    // ---------------------------------------------------------------- state
    logic [0:0]    state_q,       state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q,     discard_d;
    logic [CW-1:0] fifo_count_q,  fifo_count_d;
    logic [PW-1:0] fifo_wr_q,     fifo_wr_d;
    logic [PW-1:0] fifo_rd_q,     fifo_rd_d;
    logic [PW-1:0] pcq_wr_q,      pcq_wr_d;
    logic [PW-1:0] pcq_rd_q,      pcq_rd_d;

    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];
    logic          fifo_fault_q [DEPTH];
    logic          fifo_fault_d [DEPTH];
    logic [31:0]   pcq_mem_q    [DEPTH];
    logic [31:0]   pcq_mem_d    [DEPTH];

    // ---------------------------------------------------------------- decode
    logic          misaligned_s;
    logic [CW:0]   credit_used_s;
    logic          can_issue_s;
    logic          imem_req_s;
    logic          grant_s;
    logic          rsp_s;
    logic          rsp_keep_s;
    logic          fault_push_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   push_instr_s;
    logic [31:0]   push_pc_s;
    logic          push_fault_s;

    // Issue, response and push/pop qualifiers.
    always_comb begin
        misaligned_s  = (pc[1:0] != 2'b00);

        // Buffered entries count against the same credit as reads in flight.
        credit_used_s = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
        can_issue_s   = (state_q == ST_FETCH) && (credit_used_s < DEPTH_W);

        // Reset masks the request so that every output is quiet while rst is high.
        imem_req_s    = can_issue_s & ~branch_en & ~misaligned_s & ~rst;
        grant_s       = imem_req_s & imem_gnt;

        // Data is only expected while something is in flight.
        // A stray rvalid with nothing pending is ignored.
        rsp_s         = imem_rvalid & (outstanding_q != '0);

        // Data arriving in a redirect cycle belongs to the old path and is dropped.
        rsp_keep_s    = rsp_s & (discard_q == '0) & ~branch_en;

        // The fault entry waits until every earlier read has returned.
        // This keeps the fault in program order behind that read data.
        fault_push_s  = ~rst & (state_q == ST_FETCH) & ~branch_en & misaligned_s &
                        (outstanding_q == '0) & (fifo_count_q < DEPTH_C);

        // A fault push needs outstanding==0, so it can never collide with a response.
        push_s        = rsp_keep_s | fault_push_s;
        pop_s         = if_valid & if_ready;

        if (fault_push_s) begin
            push_instr_s = NOP_INSTR;
            push_pc_s    = pc;
            push_fault_s = 1'b1;
        end else begin
            push_instr_s = imem_rdata;
            push_pc_s    = pcq_mem_q[pcq_rd_q];
            push_fault_s = 1'b0;
        end
    end

    // Next-state logic for counters, the request-PC queue and the output FIFO.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_count_d  = fifo_count_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_fault_d  = fifo_fault_q;
        pcq_mem_d     = pcq_mem_q;

        // The PC queue mirrors the in-flight reads.
        // It keeps popping across a redirect so that dropped responses stay in step.
        if (grant_s) begin
            pcq_mem_d[pcq_wr_q] = pc;
            pcq_wr_d            = ptr_inc(pcq_wr_q);
        end else begin
            pcq_wr_d            = pcq_wr_q;
        end

        if (rsp_s) begin
            pcq_rd_d = ptr_inc(pcq_rd_q);
        end else begin
            pcq_rd_d = pcq_rd_q;
        end

        case ({grant_s, rsp_s})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (branch_en) begin
            // No grant is possible in a redirect cycle.
            // So outstanding_d is exactly the set of reads still to come back.
            discard_d    = outstanding_d;
            state_d      = ST_FETCH;
            fifo_count_d = '0;
            fifo_wr_d    = '0;
            fifo_rd_d    = '0;
        end else begin
            if (rsp_s && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end else begin
                discard_d = discard_q;
            end

            if (fault_push_s) begin
                state_d = ST_FAULT;
            end else begin
                state_d = state_q;
            end

            if (push_s) begin
                fifo_instr_d[fifo_wr_q] = push_instr_s;
                fifo_pc_d[fifo_wr_q]    = push_pc_s;
                fifo_fault_d[fifo_wr_q] = push_fault_s;
                fifo_wr_d               = ptr_inc(fifo_wr_q);
            end else begin
                fifo_wr_d               = fifo_wr_q;
            end

            if (pop_s) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end else begin
                fifo_rd_d = fifo_rd_q;
            end

            case ({push_s, pop_s})
                2'b10:   fifo_count_d = fifo_count_q + CW'(1);
                2'b01:   fifo_count_d = fifo_count_q - CW'(1);
                default: fifo_count_d = fifo_count_q;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_count_q  <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            fifo_instr_q  <= '{default: 32'h0000_0000};
            fifo_pc_q     <= '{default: 32'h0000_0000};
            fifo_fault_q  <= '{default: 1'b0};
            pcq_mem_q     <= '{default: 32'h0000_0000};
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            fifo_instr_q  <= fifo_instr_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_fault_q  <= fifo_fault_d;
            pcq_mem_q     <= pcq_mem_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    // The decode side comes straight from registers.
    // The memory side is combinational because program_counter must see the
    // advance in the same cycle as the grant.
    always_comb begin
        imem_req   = imem_req_s;
        imem_addr  = pc;
        pc_advance = grant_s | fault_push_s;
        if_valid   = (fifo_count_q != '0);
        if_instr   = fifo_instr_q[fifo_rd_q];
        if_pc      = fifo_pc_q[fifo_rd_q];
        if_fault   = fifo_fault_q[fifo_rd_q];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. It contains:
//   - a program-counter model and an in-order memory model with a settable
//     response latency;
//   - a scoreboard of expected decode entries.
// The stimulus process pushes expected entries into the scoreboard. A separate
// monitor pops and compares them on every decode handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic [31:0] pc          = 32'h0000_0000;
    logic        branch_en   = 1'b0;
    logic [31:0] tgt         = 32'h0000_0000;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0000_0000;
    logic        if_valid;
    logic        if_ready    = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int cyc   = 0;
    int n_gnt = 0;
    int n_adv = 0;

    logic [31:0] exp_pc_q    [$];
    logic [31:0] exp_instr_q [$];
    logic        exp_fault_q [$];
    logic [31:0] mem_addr_q  [$];
    int          mem_due_q   [$];

    instr_fetch #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .branch_en   (branch_en),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_fault    (if_fault)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is derived from its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] ins, input logic f);
        exp_pc_q.push_back(p);
        exp_instr_q.push_back(ins);
        exp_fault_q.push_back(f);
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(base + 32'(4 * i), mem_word(base + 32'(4 * i)), 1'b0);
        end
    endtask

    task automatic run_until_empty(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && exp_pc_q.size() != 0; i++) begin
            tick();
        end
        n_cmp++;
        if (exp_pc_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d entries never delivered, required 0", name, exp_pc_q.size());
            exp_pc_q.delete();
            exp_instr_q.delete();
            exp_fault_q.delete();
        end
        if_ready = 1'b0;
        imem_gnt = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] t);
        branch_en = 1'b1;
        tgt       = t;
        tick();
        branch_en = 1'b0;
        imem_gnt  = 1'b0;
        if_ready  = 1'b0;
        repeat (3) tick();
    endtask

    // Program counter model: redirect wins over increment.
    always @(posedge clk) begin
        if (rst) begin
            pc    <= 32'h0000_0000;
            n_adv <= 0;
        end else begin
            if (branch_en) begin
                pc <= tgt;
            end else if (pc_advance) begin
                pc <= pc + 32'd4;
            end
            if (pc_advance) begin
                n_adv <= n_adv + 1;
            end
        end
    end

    // In-order memory with a fixed response latency of lat cycles after the grant.
    always @(posedge clk) begin
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0000_0000;
            cyc         <= 0;
            n_gnt       <= 0;
        end else begin
            if (imem_req && imem_gnt) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cyc + lat);
                n_gnt <= n_gnt + 1;
            end
            if (mem_due_q.size() != 0 && mem_due_q[0] == cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(mem_addr_q[0]);
                mem_addr_q.pop_front();
                mem_due_q.pop_front();
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= 32'h0000_0000;
            end
            cyc <= cyc + 1;
        end
    end

    // Scoreboard monitor: compares every accepted decode entry.
    // It also checks that reads in flight never exceed the credit limit.
    always @(negedge clk) begin : monitor
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        if (!rst) begin
            if (mem_addr_q.size() > DEPTH) begin
                n_cmp++;
                n_bad++;
                $display("FAIL credit: %0d reads in flight, required <= %0d", mem_addr_q.size(), DEPTH);
            end
            if (if_valid && if_ready) begin
                if (exp_pc_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_entry: got pc %h, required no entry", if_pc);
                end else begin
                    e_pc    = exp_pc_q.pop_front();
                    e_instr = exp_instr_q.pop_front();
                    e_fault = exp_fault_q.pop_front();
                    chk32("if_pc",    if_pc,             e_pc);
                    chk32("if_instr", if_instr,          e_instr);
                    chk32("if_fault", {31'd0, if_fault}, {31'd0, e_fault});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int g0;
        int a0;

        // 1: reset held for two cycles; everything quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk32("rst_req", {31'd0, imem_req},   32'd0);
            chk32("rst_adv", {31'd0, pc_advance}, 32'd0);
            chk32("rst_vld", {31'd0, if_valid},   32'd0);
            chk32("rst_pc",  if_pc,               32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 6: grant held low for 3 cycles; request at pc 0 stays up and the PC holds.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk32("stall_req",  {31'd0, imem_req},   32'd1);
            chk32("stall_addr", imem_addr,           32'h0000_0000);
            chk32("stall_adv",  {31'd0, pc_advance}, 32'd0);
            tick();
        end

        // 2: streaming fetch with 1-cycle latency; first if_valid two cycles after the grant.
        lat      = 1;
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        push_stream(32'h0000_0000, 6);
        @(negedge clk);
        chk32("first_adv",  {31'd0, pc_advance}, 32'd1);
        chk32("lat_vld_n0", {31'd0, if_valid},   32'd0);
        tick();
        @(negedge clk);
        chk32("lat_vld_n1", {31'd0, if_valid},   32'd0);
        tick();
        @(negedge clk);
        chk32("lat_vld_n2", {31'd0, if_valid},   32'd1);
        run_until_empty(60, "stream");
        do_branch(32'h0000_0040);

        // 3: decode back-pressure; exactly DEPTH grants, then the fetch stalls.
        g0       = n_gnt;
        imem_gnt = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk32("bp_grants", 32'(n_gnt - g0),      32'(DEPTH));
        chk32("bp_req",    {31'd0, imem_req},   32'd0);
        chk32("bp_adv",    {31'd0, pc_advance}, 32'd0);
        chk32("bp_addr",   imem_addr,           32'h0000_0048);
        tick();
        push_stream(32'h0000_0040, 4);
        if_ready = 1'b1;
        run_until_empty(60, "backpressure");
        do_branch(32'h0000_0080);

        // 4: redirect with two reads in flight (2-cycle latency); both are dropped.
        lat      = 2;
        imem_gnt = 1'b1;
        tick();
        tick();
        branch_en = 1'b1;
        tgt       = 32'h0000_0010;
        if_ready  = 1'b1;
        push_stream(32'h0000_0010, 3);
        @(negedge clk);
        chk32("flush_req", {31'd0, imem_req}, 32'd0);
        tick();
        branch_en = 1'b0;
        run_until_empty(60, "flush");

        // 5: misaligned PC gives one fault entry; no issue until the next redirect.
        lat = 1;
        push_exp(32'h0000_0006, NOP, 1'b1);
        a0 = n_adv;
        do_branch(32'h0000_0006);
        if_ready = 1'b1;
        imem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk32("mis_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        run_until_empty(10, "fault");
        chk32("mis_adv",  32'(n_adv - a0), 32'd1);
        chk32("mis_addr", imem_addr,       32'h0000_000A);
        imem_gnt  = 1'b1;
        if_ready  = 1'b1;
        push_stream(32'h0000_0020, 3);
        branch_en = 1'b1;
        tgt       = 32'h0000_0020;
        tick();
        branch_en = 1'b0;
        @(negedge clk);
        chk32("resume_req",  {31'd0, imem_req}, 32'd1);
        chk32("resume_addr", imem_addr,         32'h0000_0020);
        tick();
        run_until_empty(60, "resume");

        // After a redirect with fetch paused, nothing reaches decode.
        do_branch(32'h0000_0000);
        @(negedge clk);
        chk32("post_flush_vld", {31'd0, if_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
